// File: rtl/pcx_core_arb.sv
// Shares one PCX output stream among several SPARC cores. Each core has a capture stage and a
// FIFO; a round-robin arbiter with atomic-pair locking feeds a registered valid/ready output.
module pcx_core_arb #(
  parameter int unsigned NUM_CORES  = 2,
  parameter int unsigned PCX_WIDTH  = 124,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                           gclk,
  input  logic                           reset,
  input  logic [5*NUM_CORES-1:0]         spc_pcx_req_pq,
  input  logic [NUM_CORES-1:0]           spc_pcx_atom_pq,
  input  logic [PCX_WIDTH*NUM_CORES-1:0] spc_pcx_data_pa,
  output logic [5*NUM_CORES-1:0]         pcx_spc_grant_px,
  output logic                           arb_pcx_valid,
  input  logic                           arb_pcx_ready,
  output logic [PCX_WIDTH-1:0]           arb_pcx_data,
  output logic [4:0]                     arb_pcx_req,
  output logic                           arb_pcx_atom,
  output logic [2:0]                     arb_pcx_core,
  output logic [NUM_CORES-1:0]           arb_ovf_err
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned OccW  = PtrW + 1;
  localparam int unsigned CoreW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  // Entry layout: {data, req[4:0], atom}
  localparam int unsigned EntW  = PCX_WIDTH + 6;

  typedef enum logic [0:0] {StArb, StLock} state_e;

  state_e                 state_q, state_d;
  logic [CoreW-1:0]       lock_core_q, lock_core_d;
  logic [CoreW-1:0]       rr_ptr_q, rr_ptr_d;

  logic                   out_vld_q;
  logic [PCX_WIDTH-1:0]   out_data_q;
  logic [4:0]             out_req_q;
  logic                   out_atom_q;
  logic [CoreW-1:0]       out_core_q;
  logic [5*NUM_CORES-1:0] grant_q, grant_d;

  logic [NUM_CORES-1:0]   fifo_empty;
  logic [NUM_CORES-1:0]   fifo_pop;
  logic [EntW-1:0]        head [NUM_CORES];
  logic [EntW-1:0]        head_sel;

  logic                   hs;
  logic                   load_en;
  logic                   load;
  logic                   pick_found;
  logic [CoreW-1:0]       pick_core;
  logic [CoreW-1:0]       cand;
  int unsigned            idx;

  assign hs      = out_vld_q & arb_pcx_ready;
  assign load_en = ~out_vld_q | arb_pcx_ready;

  for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
    logic            pend_vld_q;
    logic [4:0]      pend_req_q;
    logic            pend_atom_q;
    logic [EntW-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW:0]   wr_ptr_q, rd_ptr_q;
    logic [OccW-1:0] occ_q;
    logic            ovf_q;
    logic            hs_c;
    logic            push;
    logic [4:0]      req_c;

    assign req_c = spc_pcx_req_pq[c*5 +: 5];
    // Occupancy includes the entry sitting in the output register; a slot is freed on acceptance.
    assign hs_c  = hs && (out_core_q == CoreW'(c));
    assign push  = pend_vld_q && ((occ_q != OccW'(FIFO_DEPTH)) || hs_c);

    assign fifo_empty[c]  = (wr_ptr_q == rd_ptr_q);
    assign head[c]        = mem_q[rd_ptr_q[PtrW-1:0]];
    assign arb_ovf_err[c] = ovf_q;

    always_ff @(posedge gclk) begin
      if (reset) begin
        pend_vld_q  <= 1'b0;
        pend_req_q  <= '0;
        pend_atom_q <= 1'b0;
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        occ_q       <= '0;
        ovf_q       <= 1'b0;
      end else begin
        pend_vld_q  <= |req_c;
        pend_req_q  <= req_c;
        pend_atom_q <= spc_pcx_atom_pq[c] & (|req_c);
        if (push) begin
          mem_q[wr_ptr_q[PtrW-1:0]] <= {spc_pcx_data_pa[c*PCX_WIDTH +: PCX_WIDTH],
                                        pend_req_q, pend_atom_q};
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end
        if (fifo_pop[c]) rd_ptr_q <= rd_ptr_q + 1'b1;
        occ_q <= occ_q + OccW'(push) - OccW'(hs_c);
        if (pend_vld_q && !push) ovf_q <= 1'b1;
      end
    end
  end

  always_comb begin
    pick_found = 1'b0;
    pick_core  = '0;
    cand       = '0;
    idx        = 0;
    if (state_q == StLock) begin
      pick_found = ~fifo_empty[lock_core_q];
      pick_core  = lock_core_q;
    end else begin
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        idx = 32'(rr_ptr_q) + i;
        if (idx >= NUM_CORES) idx = idx - NUM_CORES;
        cand = CoreW'(idx);
        if (!pick_found && !fifo_empty[cand]) begin
          pick_found = 1'b1;
          pick_core  = cand;
        end
      end
    end
  end

  assign load     = load_en & pick_found;
  assign head_sel = head[pick_core];

  always_comb begin
    fifo_pop    = '0;
    state_d     = state_q;
    lock_core_d = lock_core_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      fifo_pop[pick_core] = 1'b1;
      if (state_q == StArb) begin
        rr_ptr_d = (pick_core == CoreW'(NUM_CORES - 1)) ? '0 : pick_core + 1'b1;
        if (head_sel[0]) begin
          state_d     = StLock;
          lock_core_d = pick_core;
        end
      end else begin
        // Second half of the pair: release the lock without advancing the pointer.
        state_d = StArb;
      end
    end
  end

  always_comb begin
    grant_d = '0;
    for (int unsigned c = 0; c < NUM_CORES; c++) begin
      if (hs && (out_core_q == CoreW'(c))) grant_d[c*5 +: 5] = out_req_q;
    end
  end

  always_ff @(posedge gclk) begin
    if (reset) begin
      state_q     <= StArb;
      lock_core_q <= '0;
      rr_ptr_q    <= '0;
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      out_req_q   <= '0;
      out_atom_q  <= 1'b0;
      out_core_q  <= '0;
      grant_q     <= '0;
    end else begin
      state_q     <= state_d;
      lock_core_q <= lock_core_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      if (load_en) begin
        out_vld_q <= pick_found;
        if (pick_found) begin
          out_data_q <= head_sel[EntW-1:6];
          out_req_q  <= head_sel[5:1];
          out_atom_q <= head_sel[0];
          out_core_q <= pick_core;
        end
      end
    end
  end

  assign pcx_spc_grant_px = grant_q;
  assign arb_pcx_valid    = out_vld_q;
  assign arb_pcx_data     = out_data_q;
  assign arb_pcx_req      = out_req_q;
  assign arb_pcx_atom     = out_atom_q;
  assign arb_pcx_core     = 3'(out_core_q);

endmodule
